video_frame_capture: RTL and testbench

VIDEO_FRAME_CAPTURE -- requirements
Module: video_frame_capture

---
 rtl/video_frame_capture_pkg.sv | 19 +
 rtl/video_frame_capture_if.sv | 23 ++
 rtl/video_frame_capture_sync_edge_det.sv | 21 ++
 rtl/video_frame_capture.sv | 168 ++++++++++++++++
 tb/tb_video_frame_capture.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_frame_capture_pkg.sv
// rtl/video_frame_capture_pkg.sv - shared types and constants for the frame capture block
package vfc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SYNC  = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_CAPTURE    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_LINE_LONG  = 2'b01;
  localparam logic [1:0] ERR_LINE_SHORT = 2'b10;
  localparam logic [1:0] ERR_FRAME_SIZE = 2'b11;

  localparam int DEF_IMG_HDISP = 640;
  localparam int DEF_IMG_VDISP = 480;

endpackage

// File: rtl/video_frame_capture_if.sv
// rtl/video_frame_capture_if.sv - video input stream and frame-buffer write port
interface video_frame_capture_if #(
  parameter int DW = 24,
  parameter int AW = 19
);
  logic          per_frame_vsync;
  logic          per_frame_href;
  logic          per_frame_clken;
  logic [DW-1:0] per_img_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_data,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/video_frame_capture_sync_edge_det.sv
// rtl/video_frame_capture_sync_edge_det.sv - registers a level and flags its rising/falling edges
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic din_q;
  logic din_d;

  always_comb din_d = din;

  always_ff @(posedge clk) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din_d;
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;
endmodule

// File: rtl/video_frame_capture.sv
// rtl/video_frame_capture.sv - captures one complete video frame into a linear frame buffer
module video_frame_capture
  import vfc_pkg::*;
#(
  parameter int IMG_HDISP = DEF_IMG_HDISP,
  parameter int IMG_VDISP = DEF_IMG_VDISP,
  parameter int DW        = 24
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  video_frame_capture_if.slave vif,
  input  logic                 arm,
  input  logic                 cont,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy
);
  localparam int AW = $clog2(IMG_HDISP * IMG_VDISP);
  localparam int XW = $clog2(IMG_HDISP + 1);
  localparam int YW = $clog2(IMG_VDISP + 1);
  localparam logic [XW-1:0] X_MAX  = XW'(IMG_HDISP);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_VDISP);
  localparam logic [AW-1:0] A_LAST = AW'(IMG_HDISP * IMG_VDISP - 1);

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d, y_line;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_seen_q, err_seen_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          frame_err_q, frame_err_d;
  logic          frame_done_q, frame_done_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [1:0]    err_now;
  logic          accept;
  logic          vsync_rise, vsync_fall, href_rise, href_fall;

  sync_edge_det u_vsync_det (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .din  (vif.per_frame_vsync),
    .rise (vsync_rise),
    .fall (vsync_fall)
  );

  sync_edge_det u_href_det (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .din  (vif.per_frame_href),
    .rise (href_rise),
    .fall (href_fall)
  );

  assign accept = vif.per_frame_href & vif.per_frame_clken;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    err_seen_d   = err_seen_q;
    err_code_d   = err_code_q;
    frame_err_d  = 1'b0;
    frame_done_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    err_now      = ERR_NONE;
    y_line       = y_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d    = ST_WAIT_SYNC;
          err_code_d = ERR_NONE;
        end
      end
      ST_WAIT_SYNC: begin
        if (!vif.per_frame_vsync) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (vsync_rise) begin
          state_d    = ST_CAPTURE;
          x_d        = '0;
          y_d        = '0;
          addr_d     = '0;
          err_seen_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        // href is high whenever a pixel is accepted, so line close and accept never coincide
        if (href_fall) begin
          if (x_q < X_MAX) err_now = ERR_LINE_SHORT;
          if (y_q != Y_MAX) y_line = y_q + 1'b1;
          x_d = '0;
        end else if (accept) begin
          if (y_q == Y_MAX) begin
            err_now = ERR_FRAME_SIZE;
          end else if (x_q == X_MAX) begin
            err_now = ERR_LINE_LONG;
          end else begin
            x_d = x_q + 1'b1;
            if (!err_seen_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = vif.per_img_data;
              if (addr_q != A_LAST) addr_d = addr_q + 1'b1;
            end
          end
        end
        y_d = y_line;
        // frame size uses the post-close line count so a coincident href fall is included
        if (vsync_fall) begin
          if (err_now == ERR_NONE && y_line != Y_MAX) err_now = ERR_FRAME_SIZE;
          frame_done_d = 1'b1;
          state_d      = cont ? ST_WAIT_FRAME : ST_IDLE;
        end
        if (err_now != ERR_NONE && !err_seen_q) begin
          err_seen_d  = 1'b1;
          err_code_d  = err_now;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      err_seen_q   <= 1'b0;
      err_code_q   <= ERR_NONE;
      frame_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      err_seen_q   <= err_seen_d;
      err_code_q   <= err_code_d;
      frame_err_q  <= frame_err_d;
      frame_done_q <= frame_done_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  logic unused_href_rise;
  assign unused_href_rise = href_rise;

  assign vif.wr_en   = wr_en_q;
  assign vif.wr_addr = wr_addr_q;
  assign vif.wr_data = wr_data_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_video_frame_capture.sv
// tb/tb_video_frame_capture.sv - randomized directed bench with a frame-level reference model
module tb_video_frame_capture;
  import vfc_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 24;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       arm = 1'b0;
  logic       cont = 1'b0;
  logic       frame_done, frame_err, busy;
  logic [1:0] err_code;

  video_frame_capture_if #(.DW(DW), .AW(AW)) vif ();

  video_frame_capture #(.IMG_HDISP(H), .IMG_VDISP(V), .DW(DW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .vif        (vif.slave),
    .arm        (arm),
    .cont       (cont),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  wr_t got_q[$];
  int  done_cnt = 0, ferr_cnt = 0, done_cyc = -1, busy_low = 0;
  bit  watch_busy = 1'b0;

  always @(negedge sys_clk) begin
    wr_t w;
    if (vif.wr_en === 1'b1) begin
      w.addr = vif.wr_addr;
      w.data = vif.wr_data;
      w.cyc  = cyc;
      got_q.push_back(w);
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (watch_busy && busy !== 1'b1) busy_low++;
  end

  int         checks = 0, errors = 0;
  logic [DW-1:0] pix [0:5][0:15];
  int         acc_cyc[$];
  wr_t        exp_q[$];
  logic [1:0] exp_err;
  int         fall_cyc;
  int         got_base, done_base, ferr_base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic gen_pix();
    for (int l = 0; l < 6; l++)
      for (int p = 0; p < 16; p++)
        pix[l][p] = DW'($urandom);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (2) tick();
  endtask

  // Drives n pixels of line l with random clken gaps; vfall drops vsync together with the last pixel.
  task automatic send_line(input int l, input int n, input bit vfall);
    for (int p = 0; p < n; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        vif.per_frame_href  = 1'b1;
        vif.per_frame_clken = 1'b0;
        tick();
      end
      vif.per_frame_href  = 1'b1;
      vif.per_frame_clken = 1'b1;
      vif.per_img_data    = pix[l][p];
      if (vfall && p == n - 1) begin
        vif.per_frame_vsync = 1'b0;
        fall_cyc = cyc;
      end
      acc_cyc.push_back(cyc);
      tick();
    end
    vif.per_frame_clken = 1'b0;
  endtask

  // mode 0: vsync falls after blanking; 1: href and vsync fall together; 2: vsync falls with the last pixel
  task automatic send_frame(input int nl, input int cnt[6], input int mode);
    acc_cyc.delete();
    gen_pix();
    vif.per_frame_vsync = 1'b1;
    repeat (3) tick();
    for (int l = 0; l < nl; l++) begin
      send_line(l, cnt[l], (mode == 2) && (l == nl - 1));
      if (l == nl - 1 && mode == 1) begin
        vif.per_frame_href  = 1'b0;
        vif.per_frame_vsync = 1'b0;
        fall_cyc = cyc;
        tick();
      end else if (l == nl - 1 && mode == 2) begin
        vif.per_frame_href = 1'b0;
        tick();
      end else begin
        vif.per_frame_href = 1'b0;
        repeat (2) tick();
      end
    end
    if (mode == 0) begin
      tick();
      vif.per_frame_vsync = 1'b0;
      fall_cyc = cyc;
    end
    repeat (4) tick();
  endtask

  // Expected writes and error from the line/pixel counts alone.
  task automatic model_frame(input int nl, input int cnt[6], input int mode);
    int  k = 0;
    bit  err = 1'b0;
    int  closed;
    wr_t e;
    exp_q.delete();
    exp_err = ERR_NONE;
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < cnt[l]; p++) begin
        if (!err) begin
          if (l >= V) begin
            err = 1'b1;
            exp_err = ERR_FRAME_SIZE;
          end else if (p >= H) begin
            err = 1'b1;
            exp_err = ERR_LINE_LONG;
          end else begin
            e.addr = AW'(l * H + p);
            e.data = pix[l][p];
            e.cyc  = acc_cyc[k] + 1;
            exp_q.push_back(e);
          end
        end
        k++;
      end
      if (!err && !(mode == 2 && l == nl - 1) && cnt[l] < H) begin
        err = 1'b1;
        exp_err = ERR_LINE_SHORT;
      end
    end
    closed = (mode == 2) ? nl - 1 : nl;
    if (!err && closed != V) exp_err = ERR_FRAME_SIZE;
  endtask

  task automatic snapshot();
    got_base  = got_q.size();
    done_base = done_cnt;
    ferr_base = ferr_cnt;
  endtask

  task automatic check_frame(input string tag);
    int n;
    n = got_q.size() - got_base;
    check({tag, "_nwr"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check({tag, "_addr"}, got_q[got_base + i].addr, exp_q[i].addr);
      check({tag, "_data"}, got_q[got_base + i].data, exp_q[i].data);
      check({tag, "_wlat"}, got_q[got_base + i].cyc, exp_q[i].cyc);
    end
    check({tag, "_done_n"}, done_cnt - done_base, 1);
    check({tag, "_done_t"}, done_cyc, fall_cyc + 1);
    check({tag, "_err_code"}, err_code, exp_err);
    check({tag, "_ferr_n"}, ferr_cnt - ferr_base, (exp_err != ERR_NONE) ? 1 : 0);
  endtask

  task automatic run_frame(input string tag, input int nl, input int cnt[6], input int mode);
    snapshot();
    send_frame(nl, cnt, mode);
    model_frame(nl, cnt, mode);
    check_frame(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, vif.wr_en, 1'b0);
    check({tag, "_wr_addr"}, vif.wr_addr, '0);
    check({tag, "_wr_data"}, vif.wr_data, '0);
    check({tag, "_done"}, frame_done, 1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
    check({tag, "_err_code"}, err_code, 2'b00);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int full[6];
    int rc[6];
    int nl, mode;
    full = '{H, H, H, H, 0, 0};
    vif.per_frame_vsync = 1'b1;
    vif.per_frame_href  = 1'b1;
    vif.per_frame_clken = 1'b1;
    vif.per_img_data    = '1;
    repeat (3) tick();
    check_all_zero("reset");
    vif.per_frame_vsync = 1'b0;
    vif.per_frame_href  = 1'b0;
    vif.per_frame_clken = 1'b0;
    vif.per_img_data    = '0;
    sys_rst = 1'b0;
    repeat (3) tick();

    // clean frame
    pulse_arm();
    run_frame("clean", 4, full, 0);
    check("clean_busy", busy, 1'b0);

    // armed in the middle of a frame: that frame is skipped
    gen_pix();
    acc_cyc.delete();
    vif.per_frame_vsync = 1'b1;
    repeat (2) tick();
    send_line(0, H, 1'b0);
    vif.per_frame_href = 1'b0;
    snapshot();
    pulse_arm();
    for (int l = 1; l < 4; l++) begin
      send_line(l, H, 1'b0);
      vif.per_frame_href = 1'b0;
      repeat (2) tick();
    end
    vif.per_frame_vsync = 1'b0;
    repeat (4) tick();
    check("midarm_nwr", got_q.size() - got_base, 0);
    check("midarm_done", done_cnt - done_base, 0);
    run_frame("midarm_next", 4, full, 0);

    // long line
    pulse_arm();
    run_frame("long", 4, '{H, H, H + 1, H, 0, 0}, 0);
    repeat (3) tick();
    check("long_sticky", err_code, ERR_LINE_LONG);

    // short frame
    pulse_arm();
    run_frame("short_frame", 3, '{H, H, H, 0, 0, 0}, 0);

    // short line
    pulse_arm();
    run_frame("short_line", 4, '{H, H - 3, H, H, 0, 0}, 0);

    // href and vsync fall together; vsync falls with the last pixel
    pulse_arm();
    run_frame("tight_end", 4, full, 1);
    pulse_arm();
    run_frame("vfall_pix", 4, full, 2);

    // continuous mode
    cont = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    watch_busy = 1'b1;
    tick();
    run_frame("cont0", 4, full, 0);
    run_frame("cont1", 4, full, 0);
    run_frame("cont2", 4, full, 0);
    watch_busy = 1'b0;
    check("cont_busy_low", busy_low, 0);
    check("cont_busy_end", busy, 1'b1);
    cont = 1'b0;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    tick();
    check("cont_rst_busy", busy, 1'b0);

    // reset after ten pixels
    pulse_arm();
    gen_pix();
    acc_cyc.delete();
    snapshot();
    vif.per_frame_vsync = 1'b1;
    repeat (3) tick();
    send_line(0, H, 1'b0);
    vif.per_frame_href = 1'b0;
    repeat (2) tick();
    send_line(1, 2, 1'b0);
    sys_rst = 1'b1;
    tick();
    check("abort_nwr", got_q.size() - got_base, 10);
    check_all_zero("abort");
    sys_rst = 1'b0;
    pulse_arm();
    vif.per_frame_href = 1'b0;
    repeat (3) tick();
    vif.per_frame_vsync = 1'b0;
    repeat (4) tick();
    check("abort_no_done", done_cnt - done_base, 0);
    run_frame("abort_next", 4, full, 0);

    // random frames
    for (int it = 0; it < 8; it++) begin
      nl   = $urandom_range(3, 5);
      mode = $urandom_range(0, 2);
      for (int l = 0; l < 6; l++)
        rc[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(H - 1, H + 1)) : H;
      pulse_arm();
      run_frame("rand", nl, rc, mode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
